// File: rtl/fifomem_rr_ctrl_pkg.sv
// Shared helpers for the round-robin FIFO write-port controller.
package fifomem_rr_ctrl_pkg;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifomem_rr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above prio wins, wrapping.
module rr_arbiter
    import fifomem_rr_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = src_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    always_comb begin
        int k;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(prio) + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/fifomem_rr_ctrl.sv
// Shares one FIFO memory write port among NUM_REQ requesters (round-robin) and
// presents the FIFO head on a valid/ready read port tagged with its source index.
module fifomem_rr_ctrl
    import fifomem_rr_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 4,
    parameter  int NUM_REQ    = 4,
    parameter  int AF_THRESH  = 2,
    localparam int SRC_W      = src_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rd_valid_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [SRC_W-1:0]              rd_src_o,
    input  logic                          rd_ready_i,
    output logic [ADDR_WIDTH:0]           fill_o,
    output logic                          almost_full_o,
    output logic                          mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_waddr_o,
    output logic [DATA_WIDTH+SRC_W-1:0]   mem_wdata_o,
    output logic [ADDR_WIDTH-1:0]         mem_raddr_o,
    input  logic [DATA_WIDTH+SRC_W-1:0]   mem_rdata_i
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                  AF_ALWAYS = (AF_THRESH >= DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LIM    = (ADDR_WIDTH + 1)'(AF_THRESH);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [SRC_W-1:0]    prio;
    logic [ADDR_WIDTH:0] raw_fill;
    logic [ADDR_WIDTH:0] free_cnt;
    logic                full;
    logic                empty;
    logic [NUM_REQ-1:0]  grant;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W-1:0]    next_prio;
    logic                accept;
    logic                pop;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid_i),
        .prio      (prio),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Extra pointer MSB tells full (difference == DEPTH) from empty (difference == 0).
    assign raw_fill = wptr - rptr;
    assign full     = (raw_fill == DEPTH_V);
    assign empty    = (raw_fill == '0);

    assign fill_o        = reset_i ? '0 : raw_fill;
    assign free_cnt      = DEPTH_V - fill_o;
    assign almost_full_o = AF_ALWAYS || (free_cnt <= AF_LIM);

    assign req_ready_o = grant & {NUM_REQ{~full & ~reset_i}};
    assign accept      = |req_ready_o;
    assign next_prio   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign mem_wr_en_o = accept;
    assign mem_waddr_o = wptr[ADDR_WIDTH-1:0];
    assign mem_wdata_o = {grant_idx, req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH]};

    // Head comes straight from memory at rptr; it only moves on a pop.
    assign rd_valid_o  = ~empty & ~reset_i;
    assign mem_raddr_o = rptr[ADDR_WIDTH-1:0];
    assign rd_data_o   = mem_rdata_i[DATA_WIDTH-1:0];
    assign rd_src_o    = mem_rdata_i[DATA_WIDTH +: SRC_W];
    assign pop         = rd_valid_o & rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
            prio <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + 1'b1;
                prio <= next_prio;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifomem_rr_ctrl.sv
// Bench for fifomem_rr_ctrl: vector table, hand-written corner sequences and random
// traffic checked against a queue-based reference model.
module tb_fifomem_rr_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 4;
    localparam int AF    = 2;
    localparam int SW    = 2;
    localparam int DEPTH = 16;

    logic               clk;
    logic               reset_i;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic [SW-1:0]      rd_src;
    logic               rd_ready;
    logic [AW:0]        fill;
    logic               af;
    logic               mem_wr_en;
    logic [AW-1:0]      mem_waddr;
    logic [DW+SW-1:0]   mem_wdata;
    logic [AW-1:0]      mem_raddr;
    logic [DW+SW-1:0]   mem_rdata;

    logic [DW+SW-1:0]   mem [DEPTH];

    fifomem_rr_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .AF_THRESH  (AF)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .rd_src_o      (rd_src),
        .rd_ready_i    (rd_ready),
        .fill_o        (fill),
        .almost_full_o (af),
        .mem_wr_en_o   (mem_wr_en),
        .mem_waddr_o   (mem_waddr),
        .mem_wdata_o   (mem_wdata),
        .mem_raddr_o   (mem_raddr),
        .mem_rdata_i   (mem_rdata)
    );

    // Clock / memory stub
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    // Scoreboard / reference model state
    logic [DW+SW-1:0] exp_q[$];
    int               m_prio;
    int               m_wcount;
    int               m_grant;
    logic             m_pop;
    int               n_total;
    int               n_pass;

    typedef struct {
        logic [NR-1:0] valid;
        logic          rdy;
        logic [NR-1:0] exp_ready;
        logic [AW:0]   exp_fill;
        logic          exp_af;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_data();
        for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = 16'($urandom_range(0, 65535));
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_prio   = 0;
        m_wcount = 0;
    endtask

    // Called at negedge: compares every output against the model and records this cycle's actions.
    task automatic model_check(input string tag);
        logic [NR-1:0] er;
        int            g;
        er = '0;
        g  = -1;
        if (exp_q.size() < DEPTH) begin
            for (int o = 0; o < NR; o++) begin
                int k;
                k = (m_prio + o) % NR;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(er));
        check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'(g >= 0));
        if (g >= 0) begin
            check({tag, " mem_waddr"}, 32'(mem_waddr), 32'(m_wcount % DEPTH));
            check({tag, " mem_wdata"}, 32'(mem_wdata), 32'({SW'(g), req_data[g*DW +: DW]}));
        end
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check({tag, " rd_data"}, 32'(rd_data), 32'(exp_q[0][DW-1:0]));
            check({tag, " rd_src"}, 32'(rd_src), 32'(exp_q[0][DW +: SW]));
        end
        check({tag, " fill"}, 32'(fill), 32'(exp_q.size()));
        check({tag, " almost_full"}, 32'(af), 32'((DEPTH - exp_q.size()) <= AF));
        m_grant = g;
        m_pop   = (exp_q.size() > 0) && rd_ready;
    endtask

    task automatic model_update();
        if (m_pop) void'(exp_q.pop_front());
        if (m_grant >= 0) begin
            exp_q.push_back({SW'(m_grant), req_data[m_grant*DW +: DW]});
            m_prio = (m_grant + 1) % NR;
            m_wcount++;
        end
    endtask

    task automatic at_neg(input string tag);
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input string tag);
        at_neg(tag);
        edge_step();
    endtask

    task automatic do_reset(input int cycles, input bit keep_stim);
        reset_i = 1'b1;
        if (!keep_stim) begin
            req_valid = '0;
            rd_ready  = 1'b0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("reset req_ready", 32'(req_ready), 32'(0));
            check("reset rd_valid", 32'(rd_valid), 32'(0));
            check("reset fill", 32'(fill), 32'(0));
            check("reset mem_wr_en", 32'(mem_wr_en), 32'(0));
            check("reset almost_full", 32'(af), 32'(0));
            @(posedge clk);
        end
        #1;
        reset_i   = 1'b0;
        req_valid = '0;
        rd_ready  = 1'b0;
        model_clear();
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        m_grant   = -1;
        m_pop     = 1'b0;
        reset_i   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rd_ready  = 1'b0;
        model_clear();

        // All requesters valid, nothing read: grants rotate 0,1,2,3 until 16 entries are held.
        for (int i = 0; i < 18; i++) begin
            vecs[i].valid     = 4'hF;
            vecs[i].rdy       = 1'b0;
            vecs[i].exp_ready = (i < DEPTH) ? NR'(1 << (i % NR)) : '0;
            vecs[i].exp_fill  = (i < DEPTH) ? (AW+1)'(i) : (AW+1)'(DEPTH);
            vecs[i].exp_af    = ((i < DEPTH) ? i : DEPTH) >= (DEPTH - AF);
        end

        // Reset with no stimulus
        do_reset(3, 1'b0);
        step("idle after reset");

        // Vector table
        for (int i = 0; i < 18; i++) begin
            req_valid = vecs[i].valid;
            rd_ready  = vecs[i].rdy;
            set_data();
            at_neg("table");
            check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d fill", i), 32'(fill), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d af", i), 32'(af), 32'(vecs[i].exp_af));
            edge_step();
        end

        // Full + pop: no write this cycle, req2 accepted next cycle
        req_valid = 4'b0100;
        rd_ready  = 1'b1;
        set_data();
        at_neg("full pop");
        check("full pop ready", 32'(req_ready), 32'(0));
        check("full pop fill", 32'(fill), 32'(16));
        edge_step();
        rd_ready = 1'b0;
        at_neg("refill");
        check("refill ready", 32'(req_ready), 32'(4'b0100));
        check("refill fill", 32'(fill), 32'(15));
        edge_step();
        req_valid = '0;
        at_neg("refull");
        check("refull fill", 32'(fill), 32'(16));
        edge_step();

        // Continuous push/pop across pointer wrap, then drain
        for (int i = 0; i < 40; i++) begin
            req_valid = 4'hF;
            rd_ready  = 1'b1;
            set_data();
            step("wrap");
        end
        req_valid = '0;
        for (int i = 0; i < 20; i++) step("drain");

        // Single write into empty FIFO: no bypass, visible next cycle
        do_reset(1, 1'b0);
        req_valid = 4'b0010;
        req_data  = '0;
        req_data[1*DW +: DW] = 16'hBEEF;
        at_neg("beef write");
        check("beef same-cycle rd_valid", 32'(rd_valid), 32'(0));
        edge_step();
        req_valid = '0;
        at_neg("beef read");
        check("beef rd_valid", 32'(rd_valid), 32'(1));
        check("beef rd_data", 32'(rd_data), 32'(16'hBEEF));
        check("beef rd_src", 32'(rd_src), 32'(1));
        edge_step();
        step("beef hold");

        // Priority pointer: grant req2 -> prio 3; idle cycles keep it
        do_reset(1, 1'b0);
        req_valid = 4'b0100;
        set_data();
        step("prio setup");
        req_valid = '0;
        for (int i = 0; i < 3; i++) step("prio idle");
        req_valid = 4'b1001;
        set_data();
        at_neg("prio g3");
        check("prio first grant", 32'(req_ready), 32'(4'b1000));
        edge_step();
        set_data();
        at_neg("prio g0");
        check("prio second grant", 32'(req_ready), 32'(4'b0001));
        edge_step();
        req_valid = '0;

        // Reset mid-handshake with 9 entries held
        do_reset(1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            req_valid = 4'hF;
            set_data();
            step("fill9");
        end
        req_valid = '0;
        at_neg("fill9 done");
        check("fill9 fill", 32'(fill), 32'(9));
        edge_step();
        req_valid = 4'b0001;
        rd_ready  = 1'b1;
        set_data();
        do_reset(1, 1'b1);
        step("post reset");
        step("post reset no ghost");
        req_valid = 4'hF;
        set_data();
        at_neg("post reset prio");
        check("post reset grant0", 32'(req_ready), 32'(4'b0001));
        edge_step();
        req_valid = '0;

        // Random traffic: first biased toward filling, then toward draining
        for (int i = 0; i < 400; i++) begin
            req_valid = NR'($urandom_range(0, 15));
            rd_ready  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            set_data();
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
